bcd_seq_ctrl: RTL and testbench

Sequential binary-to-BCD conversion controller for the 7-segment display path. It replaces the combinational modulo/divide digit split with an iterative shift-and-add-3 (double-dabble) engine sequenced by a small FSM. Handshake is start/busy/done. Its registered packed BCD output feeds one `decoder` instance per digit (HEX0..HEX3) from the board-level wrapper.

---
 rtl/bcd_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_bcd_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_seq_ctrl
//
// Purpose:
//   Iterative binary-to-BCD converter for the 7-segment display path. It uses
//   shift-and-add-3 (double-dabble) and needs one cycle per input bit. A
//   two-state FSM (IDLE, SHIFT) sequences the engine. The packed BCD result is
//   registered and held between conversions, and it drives one digit decoder
//   per display digit.
//
// Handshake (valid/ready style, start/busy/done):
//   - start is sampled only while the FSM is in IDLE. When accepted, bin_in is
//     captured and busy rises on the same edge.
//   - While busy is high, start and bin_in are ignored. Requests are not
//     queued.
//   - done pulses for exactly one cycle when bcd_out has just been updated.
//     busy and done are never high together.
//   - start in the cycle done is high is accepted, so back-to-back
//     conversions run.
//
// Parameters:
//   WIDTH   binary input width (default 10)
//   DIGITS  number of BCD digits (default 4); must satisfy
//           2^WIDTH-1 <= 10^DIGITS-1
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   start      conversion request (sampled in IDLE only)
//   bin_in     binary value, captured on the accepting edge
//   busy       high while a conversion is in progress
//   done       one-cycle pulse, bcd_out just updated
//   bcd_out    packed BCD, digit i in [4i+3:4i] (units in [3:0])
//   state_dbg  current FSM state (0 = IDLE, 1 = SHIFT)
//
// Optional feature macro: BCD_AUTO_REFRESH_EN
//   When defined, a conversion also starts in IDLE whenever bin_in differs
//   from the value captured by the last accepted conversion (register last_r).
// ---------------------------------------------------------------------------
module bcd_seq_ctrl #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  state_dbg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  // Largest binary input must be representable in DIGITS decimal digits.
  function automatic bit fits(input int w, input int d);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < d; i++) p = p * 64'd10;
    return (w < 64) && (((64'd1 << w) - 64'd1) <= (p - 64'd1));
  endfunction

  if (!fits(WIDTH, DIGITS)) begin : g_size_check
    $error("bcd_seq_ctrl: 2^WIDTH-1 does not fit in DIGITS BCD digits");
  end

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   bin_r;
  logic [BW-1:0]      bcd_r;
  logic [CW-1:0]      cnt;

  logic [BW-1:0]       bcd_adj;
  logic [BW+WIDTH-1:0] shifted;
  logic                go;

  // Add-3 correction on every scratch digit, then one left shift of the
  // combined {bcd, bin} register. This is the next scratch value.
  always_comb begin
    bcd_adj = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_r} << 1;
  end

`ifdef BCD_AUTO_REFRESH_EN
  logic [WIDTH-1:0] last_r;
  // A switch change since the last accepted conversion acts as a start.
  assign go = start | (bin_in != last_r);
`else
  assign go = start;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      bin_r   <= '0;
      bcd_r   <= '0;
      cnt     <= '0;
`ifdef BCD_AUTO_REFRESH_EN
      last_r  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            bin_r <= bin_in;
            bcd_r <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_SHIFT;
`ifdef BCD_AUTO_REFRESH_EN
            last_r <= bin_in;
`endif
          end
        end
        S_SHIFT: begin
          bcd_r <= shifted[BW+WIDTH-1:WIDTH];
          bin_r <= shifted[WIDTH-1:0];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            // Final shift: publish the completed scratch value directly.
            bcd_out <= shifted[BW+WIDTH-1:WIDTH];
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_seq_ctrl
//
// Directed testbench for bcd_seq_ctrl (WIDTH=10, DIGITS=4). Expected BCD
// values are hand-computed constants. Outputs are sampled 1 time unit after
// the rising edge, and inputs are driven at the same point.
// ---------------------------------------------------------------------------
module tb_bcd_seq_ctrl;

  localparam int WIDTH  = 10;
  localparam int DIGITS = 4;

  logic                clk;
  logic                rst;
  logic                start;
  logic [WIDTH-1:0]    bin_in;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;
  logic                state_dbg;

  int checks;
  int errors;

  bcd_seq_ctrl #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .state_dbg (state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse, then follow the conversion to done. The cycle
  // count includes the accepting edge, so done must show on count 11 with
  // busy high on the 10 counts before it.
  task automatic convert(input string tag, input logic [WIDTH-1:0] v,
                         input logic [31:0] exp);
    int cycles;
    int busy_cnt;
    int overlap;
    bin_in = v;
    start  = 1'b1;
    tick();
    start    = 1'b0;
    cycles   = 1;
    busy_cnt = busy ? 1 : 0;
    overlap  = 0;
    while (!done && cycles < 30) begin
      tick();
      cycles++;
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
    end
    chk({tag, "_latency"}, 32'(cycles), 32'd11);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd10);
    chk({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
    chk({tag, "_bcd"}, {16'd0, bcd_out}, exp);
    tick();
    chk({tag, "_done_single"}, {31'd0, done}, 32'd0);
    chk({tag, "_bcd_held"}, {16'd0, bcd_out}, exp);
  endtask

  initial begin
    int cycles;
    int done_cnt;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b1;
    bin_in = 10'd5;

    // Reset held with start high: the design must stay idle.
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bcd", {16'd0, bcd_out}, 32'h0);
    chk("rst_state", {31'd0, state_dbg}, 32'd0);
    rst    = 1'b0;
    start  = 1'b0;
    bin_in = 10'd0;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_bcd", {16'd0, bcd_out}, 32'h0);

    // Full-scale value.
    convert("c1023", 10'd1023, 32'h1023);

    // Digit boundaries.
    convert("c0", 10'd0, 32'h0000);
    convert("c9", 10'd9, 32'h0009);
    convert("c10", 10'd10, 32'h0010);
    convert("c99", 10'd99, 32'h0099);
    convert("c100", 10'd100, 32'h0100);
    convert("c999", 10'd999, 32'h0999);

    // Start and bin_in changes during SHIFT are ignored.
    bin_in = 10'd512;
    start  = 1'b1;
    tick();
    start    = 1'b0;
    done_cnt = 0;
    tick();
    tick();
    bin_in = 10'd7;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    bin_in = 10'd512;
    for (int i = 0; i < 25; i++) begin
      if (done) done_cnt++;
      tick();
    end
    chk("mid_start_done_count", 32'(done_cnt), 32'd1);
    chk("mid_start_bcd", {16'd0, bcd_out}, 32'h0512);

    // Reset in the middle of a conversion discards it.
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    bin_in = 10'd1000;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst    = 1'b1;
    bin_in = 10'd0;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_bcd", {16'd0, bcd_out}, 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
    chk("mid_rst_bcd_held", {16'd0, bcd_out}, 32'h0);
    convert("c42", 10'd42, 32'h0042);

    // start held high: done every 11 cycles.
    bin_in = 10'd123;
    start  = 1'b1;
    cycles = 0;
    while (!done && cycles < 30) begin
      tick();
      cycles++;
    end
    chk("held_first_latency", 32'(cycles), 32'd11);
    chk("held_first_bcd", {16'd0, bcd_out}, 32'h0123);
    bin_in = 10'd456;
    cycles = 0;
    tick();
    cycles++;
    while (!done && cycles < 30) begin
      tick();
      cycles++;
    end
    start = 1'b0;
    chk("held_period", 32'(cycles), 32'd11);
    chk("held_second_bcd", {16'd0, bcd_out}, 32'h0456);
    tick();
    chk("held_stop_busy", {31'd0, busy}, 32'd0);
    chk("held_stop_done", {31'd0, done}, 32'd0);

`ifdef BCD_AUTO_REFRESH_EN
    // A switch change alone triggers a conversion.
    bin_in = 10'd777;
    cycles = 0;
    while (!done && cycles < 30) begin
      tick();
      cycles++;
    end
    chk("auto_latency", 32'(cycles), 32'd11);
    chk("auto_bcd", {16'd0, bcd_out}, 32'h0777);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("auto_stable_no_done", 32'(done_cnt), 32'd0);
`else
    // Without auto refresh, a switch change alone does nothing.
    bin_in   = 10'd777;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("no_auto_done", 32'(done_cnt), 32'd0);
    chk("no_auto_bcd", {16'd0, bcd_out}, 32'h0456);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
